// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
// Used by pipe_ctrl (top) and stall_merge.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      IO_WAIT = 2'd2
   } state_e;

   localparam int NSTAGE  = 5;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   // A branch flush must wait while EX or MEM is holding; it would otherwise be lost.
   function automatic logic ex_or_above(input logic [NSTAGE-2:0] req);
      return req[STG_EX] | req[STG_MEM];
   endfunction

endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// Combinational request-to-stall/flush priority encoder: the highest requesting
// stage holds itself and everything upstream, and a bubble is inserted just below.
module stall_merge
   import pipe_ctrl_pkg::*;
(
   input  logic [NSTAGE-2:0] req,
   input  logic              br_flush,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush
);

   logic hit;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      stall = '0;
      flush = '0;
      hit   = 1'b0;
      for (int i = NSTAGE-2; i >= 0; i--) begin
         if (req[i] && !hit) flush[i+1] = 1'b1;
         hit      = hit | req[i];
         stall[i] = hit;
      end
      flush[STG_IF] = flush[STG_IF] | br_flush;
      flush[STG_ID] = flush[STG_ID] | br_flush;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: start debounce, stall/flush merge, deferred
// branch flush and IO wait with timeout. Optional single-step mode: PIPE_CTRL_STEP_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ENTER_HOLD = 4,
   parameter int IO_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enter,
   input  logic              stall_req_if,
   input  logic              stall_req_id,
   input  logic              stall_req_ex,
   input  logic              stall_req_mem,
   input  logic              stall_req_io,
   input  logic              io_done,
   input  logic              flush_req,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic              running,
   output logic              io_timeout
);

   localparam int             IOW       = $clog2(IO_TIMEOUT + 1);
   localparam logic [7:0]     HOLD_LAST = 8'(ENTER_HOLD - 1);
   localparam logic [IOW-1:0] IO_LAST   = IOW'(IO_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       hold_q, hold_d;
   logic [IOW-1:0]   io_cnt_q, io_cnt_d;
   logic             pend_q, pend_d;
   logic             io_timeout_q, io_timeout_d;
   logic             running_q, running_d;

   logic [NSTAGE-2:0] req;
   logic [NSTAGE-1:0] m_stall, m_flush;
   logic              advance;
   logic              ex_mem_stall;
   logic              br_pending;
   logic              br_apply;

`ifdef PIPE_CTRL_STEP_EN
   logic enter_prev_q, enter_prev_d;
   logic step_q, step_d;

   always_comb begin
      enter_prev_d = enter;
      step_d       = enter & ~enter_prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enter_prev_q <= 1'b0;
         step_q       <= 1'b0;
      end else begin
         enter_prev_q <= enter_prev_d;
         step_q       <= step_d;
      end
   end

   assign advance = step_q;
`else
   assign advance = 1'b1;
`endif

   assign req          = {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if};
   assign ex_mem_stall = ex_or_above(req);
   assign br_pending   = flush_req | pend_q;
   // Kept outside the FSM block so the merge output never feeds back into its own input.
   assign br_apply     = (state_q == RUN) & advance & ~stall_req_io & br_pending & ~ex_mem_stall;

   stall_merge u_merge (
      .req      (req),
      .br_flush (br_apply),
      .stall    (m_stall),
      .flush    (m_flush)
   );

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      io_cnt_d     = io_cnt_q;
      pend_d       = pend_q;
      io_timeout_d = io_timeout_q;
      stall        = '1;
      flush        = '0;

      case (state_q)
         IDLE: begin
            if (!enter) begin
               hold_d = '0;
            end else if (hold_q == HOLD_LAST) begin
               hold_d  = '0;
               state_d = RUN;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end

         RUN: begin
            if (advance) begin
               if (stall_req_io) begin
                  state_d  = IO_WAIT;
                  io_cnt_d = '0;
                  pend_d   = br_pending;
               end else begin
                  stall = m_stall;
                  flush = m_flush;
                  if (br_pending) pend_d = ex_mem_stall;
               end
            end
         end

         IO_WAIT: begin
            if (io_done) begin
               io_cnt_d = '0;
               state_d  = RUN;
            end else if (io_cnt_q == IO_LAST) begin
               io_cnt_d     = '0;
               io_timeout_d = 1'b1;
               state_d      = RUN;
            end else begin
               io_cnt_d = io_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      running_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         io_cnt_q     <= '0;
         pend_q       <= 1'b0;
         io_timeout_q <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         io_cnt_q     <= io_cnt_d;
         pend_q       <= pend_d;
         io_timeout_q <= io_timeout_d;
         running_q    <= running_d;
      end
   end

   assign running    = running_q;
   assign io_timeout = io_timeout_q;

endmodule
